alu_evt_core: RTL and testbench

- Parametrised successor to the two-mode 8-bit ALU with event interrupt.
- Performs mode-'a' and mode-'b' logic ops on WIDTH-bit operands.
- Result is registered with valid qualification.
- Compares each result against a software-programmable event table of DEPTH entries and raises a sticky interrupt on a match.
- Sits between the register/stimulus interface and the interrupt controller.
- Is the DUT for the next-generation class-based environment.

---
 rtl/alu_evt_pkg.sv | 56 +++++
 rtl/alu_evt_table.sv | 57 +++++
 rtl/alu_evt_core.sv | 101 ++++++++++
 tb/tb_alu_evt_core.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_evt_pkg.sv
// Shared types and the per-bit ALU function for the alu_evt_core slice.
// The optional ALU_EVT_CORE_CNT_EN build adds nothing here.
package alu_evt_pkg;

  typedef enum logic {
    MODE_A = 1'b0,
    MODE_B = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    OP_A_AND  = 2'b00,
    OP_A_NAND = 2'b01,
    OP_A_OR   = 2'b10,
    OP_A_XOR  = 2'b11
  } op_a_e;

  typedef enum logic [1:0] {
    OP_B_XNOR = 2'b00,
    OP_B_AND  = 2'b01,
    OP_B_NOR  = 2'b10,
    OP_B_OR   = 2'b11
  } op_b_e;

  localparam int EVT_WIDTH = 8;

  // Default-width view of a table entry; the table packs the same fields at any WIDTH.
  typedef struct packed {
    logic                 valid;
    mode_e                mode;
    logic [1:0]           op;
    logic [EVT_WIDTH-1:0] value;
  } evt_entry_t;

  // One result bit; every op is bitwise, so callers apply it across the operand width.
  function automatic logic alu_compute(mode_e mode, logic [1:0] op, logic a, logic b);
    logic r;
    r = 1'b0;
    if (mode == MODE_A) begin
      case (op_a_e'(op))
        OP_A_AND:  r = a & b;
        OP_A_NAND: r = ~(a & b);
        OP_A_OR:   r = a | b;
        OP_A_XOR:  r = a ^ b;
      endcase
    end else begin
      case (op_b_e'(op))
        OP_B_XNOR: r = ~(a ^ b);
        OP_B_AND:  r = a & b;
        OP_B_NOR:  r = ~(a | b);
        OP_B_OR:   r = a | b;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_evt_table.sv
// Event table: DEPTH entries of {valid, mode, op, value}, one write port,
// parallel compare and lowest-index priority select.
module alu_evt_table
  import alu_evt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH+3:0] wr_data,
  input  logic             cmp_en,
  input  mode_e            cmp_mode,
  input  logic [1:0]       cmp_op,
  input  logic [WIDTH-1:0] cmp_value,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx
);

  logic [WIDTH+3:0] entries [DEPTH];

  // NOTE: the table is a register file, not a RAM, so every entry takes the
  // async reset; that is what guarantees valid=0 everywhere out of reset.
  // NOTE: sequential state uses non-blocking assignments so all flops see
  // pre-edge values, which is also what makes a same-cycle compare see old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      // Indices with no matching entry (>= DEPTH) simply select nothing.
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_idx == IDX_W'(i)) entries[i] <= wr_data;
      end
    end
  end

  // NOTE: defaults first so no path through the loop leaves hit/hit_idx
  // unassigned, which would otherwise infer latches.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    // Scan downwards so the lowest matching index is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cmp_en && entries[i][WIDTH+3]
          && mode_e'(entries[i][WIDTH+2]) == cmp_mode
          && entries[i][WIDTH+1:WIDTH] == cmp_op
          && entries[i][WIDTH-1:0] == cmp_value) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_evt_core.sv
// Two-mode WIDTH-bit logic ALU with registered result and sticky event interrupt.
// Define ALU_EVT_CORE_CNT_EN to add the saturating evt_cnt hit counter.
module alu_evt_core
  import alu_evt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_enable,
  input  logic             alu_enable_a,
  input  logic             alu_enable_b,
  input  logic [1:0]       alu_op_a,
  input  logic [1:0]       alu_op_b,
  input  logic [WIDTH-1:0] alu_in_a,
  input  logic [WIDTH-1:0] alu_in_b,
  input  logic             alu_irq_clr,
  input  logic             evt_wr_en,
  input  logic [IDX_W-1:0] evt_wr_idx,
  input  logic [WIDTH+3:0] evt_wr_data,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_out_vld,
  output logic             alu_err,
  output logic             alu_irq,
  output logic [IDX_W-1:0] evt_hit_idx
`ifdef ALU_EVT_CORE_CNT_EN
  ,
  output logic [15:0]      evt_cnt
`endif
);

  logic             legal;
  mode_e            mode;
  logic [1:0]       op;
  logic [WIDTH-1:0] result;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  assign legal = alu_enable & (alu_enable_a ^ alu_enable_b);
  assign mode  = alu_enable_b ? MODE_B : MODE_A;
  assign op    = alu_enable_b ? alu_op_b : alu_op_a;

  always_comb begin
    result = '0;
    for (int i = 0; i < WIDTH; i++) result[i] = alu_compute(mode, op, alu_in_a[i], alu_in_b[i]);
  end

  alu_evt_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (evt_wr_en),
    .wr_idx    (evt_wr_idx),
    .wr_data   (evt_wr_data),
    .cmp_en    (legal),
    .cmp_mode  (mode),
    .cmp_op    (op),
    .cmp_value (result),
    .hit       (hit),
    .hit_idx   (hit_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out     <= '0;
      alu_out_vld <= 1'b0;
      alu_err     <= 1'b0;
      alu_irq     <= 1'b0;
      evt_hit_idx <= '0;
    end else begin
      alu_out_vld <= legal;
      if (legal) alu_out <= result;
      if (alu_enable) alu_err <= alu_enable_a & alu_enable_b;
      // A hit outranks a clear in the same cycle.
      if (hit) begin
        alu_irq     <= 1'b1;
        evt_hit_idx <= hit_idx;
      end else if (alu_irq_clr) begin
        alu_irq <= 1'b0;
      end
    end
  end

`ifdef ALU_EVT_CORE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
    end else if (hit) begin
      if (evt_cnt != 16'hFFFF) evt_cnt <= evt_cnt + 16'd1;
    end else if (alu_irq_clr) begin
      evt_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_evt_core.sv
// Randomised bench for alu_evt_core with a behavioural model of the ALU and event table.
module tb_alu_evt_core;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alu_enable, alu_enable_a, alu_enable_b;
  logic [1:0]       alu_op_a, alu_op_b;
  logic [WIDTH-1:0] alu_in_a, alu_in_b;
  logic             alu_irq_clr;
  logic             evt_wr_en;
  logic [IDX_W-1:0] evt_wr_idx;
  logic [WIDTH+3:0] evt_wr_data;
  logic [WIDTH-1:0] alu_out;
  logic             alu_out_vld, alu_err, alu_irq;
  logic [IDX_W-1:0] evt_hit_idx;
`ifdef ALU_EVT_CORE_CNT_EN
  logic [15:0]      evt_cnt;
`endif

  alu_evt_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_enable   (alu_enable),
    .alu_enable_a (alu_enable_a),
    .alu_enable_b (alu_enable_b),
    .alu_op_a     (alu_op_a),
    .alu_op_b     (alu_op_b),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_irq_clr  (alu_irq_clr),
    .evt_wr_en    (evt_wr_en),
    .evt_wr_idx   (evt_wr_idx),
    .evt_wr_data  (evt_wr_data),
    .alu_out      (alu_out),
    .alu_out_vld  (alu_out_vld),
    .alu_err      (alu_err),
    .alu_irq      (alu_irq),
    .evt_hit_idx  (evt_hit_idx)
`ifdef ALU_EVT_CORE_CNT_EN
    ,
    .evt_cnt      (evt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state.
  logic [WIDTH-1:0] m_out = '0;
  bit               m_vld = 0, m_err = 0, m_irq = 0;
  int               m_idx = 0;
  int               m_cnt = 0;
  bit               t_valid [DEPTH];
  bit               t_mode  [DEPTH];
  logic [1:0]       t_op    [DEPTH];
  logic [WIDTH-1:0] t_val   [DEPTH];

  function automatic logic [WIDTH-1:0] ref_alu(bit mode_b, logic [1:0] op,
                                               logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    if (!mode_b) begin
      case (op)
        2'd0: return a & b;
        2'd1: return ~(a & b);
        2'd2: return a | b;
        default: return a ^ b;
      endcase
    end else begin
      case (op)
        2'd0: return ~(a ^ b);
        2'd1: return a & b;
        2'd2: return ~(a | b);
        default: return a | b;
      endcase
    end
  endfunction

  task automatic model_reset();
    m_out = '0; m_vld = 0; m_err = 0; m_irq = 0; m_idx = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      t_valid[i] = 0; t_mode[i] = 0; t_op[i] = '0; t_val[i] = '0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        bit               legal, hit, mb;
        int               hidx;
        logic [1:0]       op;
        logic [WIDTH-1:0] res;
        mb    = alu_enable_b;
        op    = mb ? alu_op_b : alu_op_a;
        res   = ref_alu(mb, op, alu_in_a, alu_in_b);
        legal = alu_enable && (alu_enable_a != alu_enable_b);
        hit   = 0;
        hidx  = 0;
        if (legal) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (!hit && t_valid[i] && t_mode[i] == mb && t_op[i] == op && t_val[i] == res) begin
              hit  = 1;
              hidx = i;
            end
          end
        end
        m_vld = legal;
        if (legal) m_out = res;
        if (alu_enable) m_err = alu_enable_a && alu_enable_b;
        if (hit) begin
          m_irq = 1;
          m_idx = hidx;
          if (m_cnt < 65535) m_cnt++;
        end else if (alu_irq_clr) begin
          m_irq = 0;
          m_cnt = 0;
        end
        if (evt_wr_en && int'(evt_wr_idx) < DEPTH) begin
          t_valid[evt_wr_idx] = evt_wr_data[WIDTH+3];
          t_mode[evt_wr_idx]  = evt_wr_data[WIDTH+2];
          t_op[evt_wr_idx]    = evt_wr_data[WIDTH+1:WIDTH];
          t_val[evt_wr_idx]   = evt_wr_data[WIDTH-1:0];
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("alu_out", 32'(alu_out), 32'(m_out));
      check("alu_out_vld", 32'(alu_out_vld), 32'(m_vld));
      check("alu_err", 32'(alu_err), 32'(m_err));
      check("alu_irq", 32'(alu_irq), 32'(m_irq));
      check("evt_hit_idx", 32'(evt_hit_idx), 32'(m_idx));
`ifdef ALU_EVT_CORE_CNT_EN
      check("evt_cnt", 32'(evt_cnt), 32'(m_cnt));
`endif
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic idle();
    alu_enable = 0; alu_enable_a = 0; alu_enable_b = 0;
    alu_op_a = '0; alu_op_b = '0; alu_in_a = '0; alu_in_b = '0;
    alu_irq_clr = 0; evt_wr_en = 0; evt_wr_idx = '0; evt_wr_data = '0;
  endtask

  task automatic issue(input bit ea, input bit eb, input logic [1:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    alu_enable = 1; alu_enable_a = ea; alu_enable_b = eb;
    alu_op_a = op; alu_op_b = op; alu_in_a = a; alu_in_b = b;
  endtask

  task automatic write_evt(input int idx, input logic [WIDTH+3:0] data);
    evt_wr_en = 1; evt_wr_idx = IDX_W'(idx); evt_wr_data = data;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  logic [WIDTH-1:0] pool [8] = '{8'h00, 8'hFF, 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h3C, 8'h03};

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n   = 1;
    started = 1;
    check("reset alu_out", 32'(alu_out), 32'h0);
    check("reset irq", 32'(alu_irq), 32'h0);

    // Mode a AND.
    issue(1, 0, 2'b00, 8'hF0, 8'h3C); tick();
    check("a_and out", 32'(alu_out), 32'h30);
    check("a_and vld", 32'(alu_out_vld), 32'h1);
    check("a_and irq", 32'(alu_irq), 32'h0);

    // Entry 2 = {1, b, NOR, 03}, then a matching mode-b NOR.
    write_evt(2, 12'hE03); tick();
    issue(0, 1, 2'b10, 8'hF0, 8'h0C); tick();
    check("b_nor out", 32'(alu_out), 32'h03);
    check("b_nor irq", 32'(alu_irq), 32'h1);
    check("b_nor idx", 32'(evt_hit_idx), 32'h2);

    // irq is sticky across non-matching issues, then cleared.
    repeat (3) begin
      issue(1, 0, 2'b00, 8'h00, 8'h00); tick();
      check("sticky irq", 32'(alu_irq), 32'h1);
    end
    alu_irq_clr = 1; tick();
    check("clr irq", 32'(alu_irq), 32'h0);

    // Entries 0 and 3 both match XOR=FF; lowest wins, hit beats clear.
    write_evt(0, 12'hBFF); tick();
    write_evt(3, 12'hBFF); tick();
    issue(1, 0, 2'b11, 8'hAA, 8'h55); tick();
    check("xor irq", 32'(alu_irq), 32'h1);
    issue(1, 0, 2'b11, 8'hAA, 8'h55); alu_irq_clr = 1; tick();
    check("hit+clr irq", 32'(alu_irq), 32'h1);
    check("hit+clr idx", 32'(evt_hit_idx), 32'h0);
    check("xor out", 32'(alu_out), 32'hFF);
    alu_irq_clr = 1; tick();
    check("clr2 irq", 32'(alu_irq), 32'h0);

    // Illegal mode holds the result and flags an error.
    issue(1, 1, 2'b00, 8'h01, 8'h01); tick();
    check("illegal err", 32'(alu_err), 32'h1);
    check("illegal vld", 32'(alu_out_vld), 32'h0);
    check("illegal out", 32'(alu_out), 32'hFF);

    // Write-then-compare ordering on entry 1.
    issue(1, 0, 2'b00, 8'hF0, 8'h3C); write_evt(1, 12'h830); tick();
    check("same-cycle write irq", 32'(alu_irq), 32'h0);
    check("legal err", 32'(alu_err), 32'h0);
    issue(1, 0, 2'b00, 8'hF0, 8'h3C); tick();
    check("next-cycle irq", 32'(alu_irq), 32'h1);
    check("next-cycle idx", 32'(evt_hit_idx), 32'h1);

    // Out-of-range index is ignored.
    write_evt(6, 12'h800); tick();
    alu_irq_clr = 1; tick();
    issue(1, 0, 2'b00, 8'h00, 8'hFF); tick();
    check("oob write irq", 32'(alu_irq), 32'h0);

    // Async reset mid-cycle with irq high.
    issue(1, 0, 2'b00, 8'hF0, 8'h3C); tick();
    #2 rst_n = 0;
    #1;
    check("async rst out", 32'(alu_out), 32'h0);
    check("async rst irq", 32'(alu_irq), 32'h0);
    check("async rst vld", 32'(alu_out_vld), 32'h0);
    @(negedge clk);
    rst_n = 1;
    issue(1, 0, 2'b00, 8'hF0, 8'h3C); tick();
    check("post-rst out", 32'(alu_out), 32'h30);
    check("post-rst irq", 32'(alu_irq), 32'h0);

    // Randomised traffic biased towards table hits.
    for (int n = 0; n < 2000; n++) begin
      alu_enable   = ($urandom_range(0, 3) != 0);
      alu_enable_a = 1'($urandom);
      alu_enable_b = 1'($urandom);
      alu_op_a     = 2'($urandom);
      alu_op_b     = 2'($urandom);
      alu_in_a     = pool[$urandom_range(0, 7)];
      alu_in_b     = pool[$urandom_range(0, 7)];
      alu_irq_clr  = ($urandom_range(0, 7) == 0);
      evt_wr_en    = ($urandom_range(0, 3) == 0);
      evt_wr_idx   = 3'($urandom);
      evt_wr_data  = {($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
                      pool[$urandom_range(0, 7)]};
      @(negedge clk);
    end
    idle();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
